// File: rtl/instr_encoder.sv
// instr_encoder: assembles MIPS R/I/J words from symbolic commands and streams them into imem (byte-op encodings enabled by INSTR_ENC_BYTE_EN)
module instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stop,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [31:0] enc;
  logic bad, acc, base_oob;
  assign base_oob  = {1'b0, base_addr} >= (ADDR_W + 1)'(DEPTH);
  assign cmd_ready = (state == RUN) && !full && !stop && (!mem_we || mem_ready);
  assign acc       = cmd_valid && cmd_ready;
  assign busy      = state != IDLE;
  assign done      = (state == DRAIN) && !mem_we;
  always_comb begin
    bad = 1'b0;
    enc = '0;
    case (cmd_op)
      4'd0:  enc = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b100000};
      4'd1:  enc = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b100010};
      4'd2:  enc = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b100100};
      4'd3:  enc = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b100101};
      4'd4:  enc = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b101010};
      4'd5:  enc = {6'b100011, cmd_rs, cmd_rt, cmd_imm};
      4'd6:  enc = {6'b101011, cmd_rs, cmd_rt, cmd_imm};
      4'd7:  enc = {6'b001000, cmd_rs, cmd_rt, cmd_imm};
      4'd8:  enc = {6'b001100, cmd_rs, cmd_rt, cmd_imm};
      4'd9:  enc = {6'b001101, cmd_rs, cmd_rt, cmd_imm};
      4'd10: enc = {6'b001010, cmd_rs, cmd_rt, cmd_imm};
      4'd11: enc = {6'b000100, cmd_rs, cmd_rt, cmd_imm};
      4'd12: enc = {6'b000101, cmd_rs, cmd_rt, cmd_imm};
      4'd13: enc = {6'b000010, cmd_target};
`ifdef INSTR_ENC_BYTE_EN
      4'd14: enc = {6'b100000, cmd_rs, cmd_rt, cmd_imm};
      4'd15: enc = {6'b101000, cmd_rs, cmd_rt, cmd_imm};
`endif
      default: bad = 1'b1;
    endcase
  end
  always_comb
    state_n = state == IDLE ? (start ? (base_oob ? DRAIN : RUN) : IDLE) :
              state == RUN  ? ((stop || full) ? DRAIN : RUN) :
              (mem_we ? DRAIN : IDLE);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        ptr  <= base_addr;
        err  <= 1'b0;
        full <= base_oob;
      end
      if (mem_we && mem_ready) mem_we <= 1'b0;
      // an accept on the same edge as a completion refills the buffer
      if (acc) begin
        mem_we    <= 1'b1;
        mem_addr  <= ptr;
        mem_wdata <= enc;
        err       <= err | bad;
        if (ptr == LAST) full <= 1'b1;
        else ptr <= ptr + 1'b1;
      end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed plan steps plus randomized sessions against a table-driven encoding model
module tb_instr_encoder;
  localparam int AW = 6;
  localparam int D  = 64;
`ifdef INSTR_ENC_BYTE_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif
  logic clk = 0, reset = 1, start = 0, stop = 0, cmd_valid = 0, mem_ready = 0;
  logic [AW-1:0] base_addr = '0;
  logic [3:0] cmd_op = '0;
  logic [4:0] cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
  logic [15:0] cmd_imm = '0;
  logic [25:0] cmd_target = '0;
  logic cmd_ready, mem_we, busy, full, err, done;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  int checks = 0, fails = 0;
  logic [31:0] fn [8] = '{32, 34, 36, 37, 42, 0, 0, 0};
  logic [31:0] opc [16] = '{0, 0, 0, 0, 0, 35, 43, 8, 12, 13, 10, 4, 5, 2, 32, 40};

  instr_encoder #(.ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stop(stop),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rs(cmd_rs),
    .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .full(full), .err(err), .done(done));

  always #5 clk = ~clk;

  function automatic bit ref_bad(input logic [31:0] op);
    return op > 13 && !BE;
  endfunction

  function automatic logic [31:0] ref_enc(input logic [31:0] op, rs, rt, rd, imm, tgt);
    if (ref_bad(op)) return 32'h0;
    if (op < 5) return rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + fn[op[2:0]];
    if (op == 13) return opc[13] * (1 << 26) + tgt;
    return opc[op[3:0]] * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                         input logic [15:0] imm, input logic [25:0] tgt);
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_imm = imm; cmd_target = tgt;
    cmd_valid = 1'b1;
  endtask

  task automatic end_session;
    stop = 1'b1; mem_ready = 1'b1; cmd_valid = 1'b0;
    for (int i = 0; i < 10 && busy; i++) tick;
    chk("drain_idle", busy, 0);
    stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit mfull, pend, merr, exp_rdy;
    int mptr;
    logic [31:0] paddr, pdata;
    #2;
    chk("rst_we", mem_we, 0); chk("rst_ready", cmd_ready, 0); chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0); chk("rst_busy", busy, 0); chk("rst_full", full, 0);
    chk("rst_err", err, 0); chk("rst_done", done, 0);
    tick; reset = 0; mem_ready = 1;
    start = 1; base_addr = 0; tick; start = 0;
    chk("run_busy", busy, 1);
    set_cmd(0, 1, 2, 3, 0, 0); #1;
    chk("add_ready", cmd_ready, 1);
    tick; cmd_valid = 0;
    chk("add_we", mem_we, 1); chk("add_addr", mem_addr, 0); chk("add_word", mem_wdata, 32'h00221820);
    tick;
    chk("add_done_we", mem_we, 0);
    stop = 1; tick;
    chk("stop_done", done, 1);
    tick; stop = 0;
    chk("stop_idle", busy, 0); chk("done_pulse_end", done, 0);
    start = 1; tick; start = 0;
    set_cmd(5, 29, 8, 0, 4, 0); tick;
    set_cmd(13, 0, 0, 0, 0, 26'h10);
    chk("lw_we", mem_we, 1); chk("lw_addr", mem_addr, 0); chk("lw_word", mem_wdata, 32'h8FA80004);
    tick; cmd_valid = 0;
    chk("j_we", mem_we, 1); chk("j_addr", mem_addr, 1); chk("j_word", mem_wdata, 32'h08000010);
    tick;
    chk("j_done_we", mem_we, 0);
    mem_ready = 0;
    set_cmd(11, 1, 2, 0, 16'hFFFF, 0); tick; cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("beq_we_hold", mem_we, 1); chk("beq_word_hold", mem_wdata, 32'h1022FFFF);
      chk("beq_addr_hold", mem_addr, 2); chk("beq_stall_ready", cmd_ready, 0);
      if (i < 2) tick;
    end
    mem_ready = 1; #1;
    chk("beq_release_ready", cmd_ready, 1);
    tick;
    chk("beq_done_we", mem_we, 0);
    end_session;
    base_addr = 62; start = 1; tick; start = 0;
    set_cmd(0, 1, 2, 3, 0, 0); tick;
    chk("b62_we", mem_we, 1); chk("b62_addr", mem_addr, 62); chk("b62_full", full, 0);
    tick;
    chk("b63_addr", mem_addr, 63); chk("b63_full", full, 1); chk("b63_ready", cmd_ready, 0);
    tick;
    chk("b3_no_write", mem_we, 0); chk("b3_done", done, 1); chk("b3_busy", busy, 1);
    cmd_valid = 0; tick;
    chk("b3_idle", busy, 0); chk("b3_done_end", done, 0);
    base_addr = 5; start = 1; tick; start = 0;
    set_cmd(15, 2, 5, 0, 8, 0); tick; cmd_valid = 0;
    chk("op15_word", mem_wdata, BE ? 32'hA0450008 : 32'h0); chk("op15_addr", mem_addr, 5);
    chk("op15_err", err, BE ? 0 : 1);
    end_session;
    chk("op15_err_sticky", err, BE ? 0 : 1);
    start = 1; tick; start = 0;
    chk("err_clear_on_start", err, 0);
    end_session;
    base_addr = 10; start = 1; tick; start = 0;
    mem_ready = 0; set_cmd(14, 3, 4, 0, 16'h1234, 0); tick; cmd_valid = 0;
    chk("midwr_we", mem_we, 1);
    #1 reset = 1; #1;
    chk("midrst_we", mem_we, 0); chk("midrst_busy", busy, 0); chk("midrst_err", err, 0);
    chk("midrst_wdata", mem_wdata, 0); chk("midrst_addr", mem_addr, 0); chk("midrst_full", full, 0);
    tick; reset = 0;
    for (int s = 0; s < 5; s++) begin
      base_addr = AW'($urandom_range(0, D - 1)); start = 1; tick; start = 0;
      mptr = int'(base_addr); mfull = 0; pend = 0; merr = 0; paddr = 0; pdata = 0;
      for (int c = 0; c < 40; c++) begin
        cmd_valid = $urandom_range(0, 3) != 0; mem_ready = $urandom_range(0, 3) != 0;
        cmd_op = 4'($urandom); cmd_rs = 5'($urandom); cmd_rt = 5'($urandom);
        cmd_rd = 5'($urandom); cmd_imm = 16'($urandom); cmd_target = 26'($urandom);
        #1;
        exp_rdy = !mfull && (!pend || mem_ready);
        chk("rnd_ready", cmd_ready, exp_rdy); chk("rnd_we", mem_we, pend); chk("rnd_err", err, merr);
        if (pend) begin
          chk("rnd_addr", mem_addr, paddr); chk("rnd_word", mem_wdata, pdata);
        end
        if (pend && mem_ready) pend = 0;
        if (cmd_valid && exp_rdy) begin
          pend = 1; paddr = mptr;
          pdata = ref_enc(cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target);
          merr = merr | ref_bad(cmd_op);
          if (mptr == D - 1) mfull = 1; else mptr++;
        end
        tick;
      end
      chk("rnd_full", full, mfull);
      end_session;
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential inverse of the main opcode decoder: accepts symbolic instruction commands over a valid/ready stream and assembles 32-bit MIPS machine words (R, I and J formats).
- Writes each word into instruction memory at an auto-incrementing address through a one-entry output buffer with a memory-ready handshake.
- Used by the bench/boot path to load programs into imem before the core runs.

Parameters:
- ADDR_W, 6, imem word-address width.
- DEPTH, 64, number of imem words; last writable address is DEPTH-1, and DEPTH must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that starts a load session; honoured only in IDLE.
- base_addr  in  ADDR_W  first write address, latched on start.
- stop  in  1  ends the session (level, sampled in RUN).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  4  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 ADDI, 8 ANDI, 9 ORI, 10 SLTI, 11 BEQ, 12 BNE, 13 J, 14 LB, 15 SB.
- cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields.
- cmd_imm  in  16  immediate or branch offset.
- cmd_target  in  26  jump target.
- mem_we  out  1  write request (output buffer valid).
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded word.
- busy  out  1  state != IDLE.
- full  out  1  address DEPTH-1 has been written this session.
- err  out  1  sticky illegal-op flag; cleared on start or reset.
- done  out  1  one-cycle pulse on DRAIN->IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0 (cmd_ready, mem_we, mem_addr, mem_wdata, busy, full, err, done); address pointer=0. Any in-flight write is dropped.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE --start--> RUN: ptr<=base_addr, err<=0, full<=0. Commands are ignored in IDLE and cmd_ready=0.
  - RUN --(stop || full)--> DRAIN. start is ignored while in RUN or DRAIN.
  - DRAIN --(!mem_we)--> IDLE, with done=1 for exactly that transition cycle.
- Handshake:
  - cmd_ready = (state==RUN) && !full && !stop && (!mem_we || mem_ready).
  - An accepted command at edge N sets mem_we=1 with mem_wdata/mem_addr valid from N+1, so latency is 1 cycle.
  - mem_we, mem_addr and mem_wdata hold stable until mem_ready=1 is sampled.
  - A write completing and a new command being accepted on the same edge gives back-to-back throughput of 1 word/cycle.
- Addressing:
  - mem_addr = ptr at accept time; ptr increments on each accept.
  - Accepting at address DEPTH-1 sets full=1; ptr does not advance past DEPTH-1 (no wrap).
  - A base_addr ≥ DEPTH immediately sets full=1 and moves to DRAIN with no writes.
- Encoding:
  - R-type = {6'b000000, rs, rt, rd, 5'b0, funct}. funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - I-type = {op, rs, rt, imm}. op: LW 100011, SW 101011, ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, BEQ 000100, BNE 000101.
  - J = {000010, target}.
  - Fields not used by the format are ignored.
- Illegal op: the word 0x00000000 (NOP) is still written at the address, and err is set sticky.

Optional Feature:
- Macro INSTR_ENC_BYTE_EN.
- Defined: op 14 encodes LB {100000, rs, rt, imm} and op 15 encodes SB {101000, rs, rt, imm}.
- Undefined: ops 14 and 15 are illegal; they write NOP and set err.

Test Plan:
- reset mid-write (mem_we=1, mem_ready=0) -> next cycle mem_we=0, busy=0, err=0, mem_wdata=0.
- start base_addr=0; ADD rd=3 rs=1 rt=2 -> mem_we at cycle+1, mem_addr=0, mem_wdata=0x00221820.
- LW rt=8 rs=29 imm=4, then J target=0x10 back-to-back with mem_ready=1 -> 0x8FA80004 @ addr 0, then 0x08000010 @ addr 1 on consecutive cycles.
- BEQ rs=1 rt=2 imm=0xFFFF with mem_ready=0 for 3 cycles -> mem_wdata=0x1022FFFF held stable, cmd_ready=0; the write completes once mem_ready=1.
- base_addr=62, DEPTH=64, three commands -> writes at 62 and 63, full=1 after the second, third command never accepted, done pulse follows.
- op 15 rs=2 rt=5 imm=8 -> with macro: 0xA0450008 and err=0; without macro: 0x00000000 and err=1 (persists until next start).
